// File: rtl/memory_bank_if.sv
// memory_bank_if: memory-bus slave port bundle for memory_bank.
// Signal names are those seen from the bank side (i_ = into the bank, o_ = out of it).
interface memory_bank_if #(
  parameter int unsigned DATA_WIDTH = 36
);
  logic [17:0]           i_address;
  logic                  i_read;
  logic                  i_write;
  logic                  i_rmw;
  logic [DATA_WIDTH-1:0] i_writedata;
  logic                  i_par_inject;
  logic [DATA_WIDTH-1:0] o_readdata;
  logic                  o_waitrequest;
  logic                  o_paused;
  logic                  o_nxm;
  logic                  o_parerr;

  modport master (
    output i_address, i_read, i_write, i_rmw, i_writedata, i_par_inject,
    input  o_readdata, o_waitrequest, o_paused, o_nxm, o_parerr
  );

  modport slave (
    input  i_address, i_read, i_write, i_rmw, i_writedata, i_par_inject,
    output o_readdata, o_waitrequest, o_paused, o_nxm, o_parerr
  );
endinterface

// File: rtl/memory_bank.sv
// memory_bank: parametrised PDP-6 core-memory bank on a single-port synchronous RAM.
// Decodes an address window, inserts programmable wait states and supports the
// read-pause-write cycle. Optional parity storage/checking: define PARITY_EN.
module memory_bank #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned BASE        = 0,
  parameter int unsigned DATA_WIDTH  = 36,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  memory_bank_if.slave bus
);

  localparam int unsigned HI_W  = 18 - ADDR_WIDTH;
`ifdef PARITY_EN
  localparam int unsigned RAM_W = DATA_WIDTH + 1;
`else
  localparam int unsigned RAM_W = DATA_WIDTH;
`endif
  localparam logic [HI_W-1:0] LP_BASE      = HI_W'(BASE);
  localparam logic [3:0]      LP_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {StIdle, StAccess, StWait, StDone, StPause} state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic                  w_latch_req;
  logic                  w_latch_wb;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_write;
  logic                  r_rmw;
  logic                  r_sel;
  logic                  r_inject;
  logic [3:0]            r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_readdata;
  logic [RAM_W-1:0]      r_mem [2**ADDR_WIDTH];
  logic [RAM_W-1:0]      w_ram_rd;
  logic [RAM_W-1:0]      w_ram_wdata;
  logic                  w_ram_we;
  logic                  w_sel_in;

  assign w_sel_in = (bus.i_address[17:ADDR_WIDTH] == LP_BASE);

  // Next-state decode; a write in PAUSE reuses the held index, a read restarts from scratch.
  always_comb begin
    w_state_d   = r_state;
    w_latch_req = 1'b0;
    w_latch_wb  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.i_read | bus.i_write) begin
          w_latch_req = 1'b1;
          w_state_d   = StAccess;
        end
      end
      StAccess: w_state_d = (WAIT_STATES > 0) ? StWait : StDone;
      StWait: begin
        if (r_wait_cnt == 4'd0) w_state_d = StDone;
      end
      StDone: w_state_d = (!r_write && r_sel && r_rmw) ? StPause : StIdle;
      StPause: begin
        if (bus.i_write) begin
          w_latch_wb = 1'b1;
          w_state_d  = StAccess;
        end else if (bus.i_read) begin
          w_latch_req = 1'b1;
          w_state_d   = StAccess;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= StIdle;
    else            r_state <= w_state_d;
  end

  // Request latch and wait-state counter; contents are don't-care after reset.
  always_ff @(posedge i_clk) begin
    if (w_latch_req) begin
      r_index  <= bus.i_address[ADDR_WIDTH-1:0];
      r_sel    <= w_sel_in;
      r_write  <= bus.i_write;
      r_rmw    <= bus.i_rmw;
      r_wdata  <= bus.i_writedata;
      r_inject <= bus.i_par_inject;
    end else if (w_latch_wb) begin
      r_write  <= 1'b1;
      r_rmw    <= 1'b0;
      r_wdata  <= bus.i_writedata;
      r_inject <= bus.i_par_inject;
    end
    if (r_state == StAccess)      r_wait_cnt <= LP_WAIT_LOAD;
    else if (r_state == StWait)   r_wait_cnt <= r_wait_cnt - 4'd1;
  end

  assign w_ram_rd = r_mem[r_index];
  // Gated by reset so an abandoned access can never reach the array.
  assign w_ram_we = (r_state == StDone) && r_write && r_sel && i_reset_n;

`ifdef PARITY_EN
  // Stored bit makes the word odd weight; injection flips it to plant an error.
  assign w_ram_wdata = {(~^r_wdata) ^ r_inject, r_wdata};
`else
  logic w_unused_inject;
  assign w_ram_wdata     = r_wdata;
  assign w_unused_inject = r_inject ^ bus.i_par_inject;
`endif

  // RAM write port, one pulse in the DONE cycle of a selected write.
  always_ff @(posedge i_clk) begin
    if (w_ram_we) r_mem[r_index] <= w_ram_wdata;
  end

  // Read register doubles as the synchronous RAM output, loaded on entry to DONE.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_readdata <= '0;
    end else if (w_state_d == StDone) begin
      if (!r_sel)        r_readdata <= '0;
      else if (!r_write) r_readdata <= w_ram_rd[DATA_WIDTH-1:0];
    end
  end

`ifdef PARITY_EN
  logic r_parerr;

  // Even weight over data+parity marks a bad word; unselected reads clear the flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_parerr <= 1'b0;
    end else if ((w_state_d == StDone) && !r_write) begin
      r_parerr <= r_sel ? ~^w_ram_rd : 1'b0;
    end
  end

  assign bus.o_parerr = r_parerr;
`else
  assign bus.o_parerr = 1'b0;
`endif

  assign bus.o_readdata    = r_readdata;
  assign bus.o_waitrequest = (r_state != StDone);
  assign bus.o_paused      = (r_state == StPause);
  assign bus.o_nxm         = (r_state == StDone) && !r_sel;

endmodule

// File: doc/memory_bank.md
Name: memory_bank

Overview:
Parametrised core-memory bank for the PDP-6 bus side of the design, a successor to the fixed 16K on-chip bank. It decodes a configurable address window and models configurable access latency through programmable wait states. It supports the PDP-6 read-pause-write (RPW) cycle, in which a read is followed by a write-back to the held address. It wraps a single-port synchronous on-chip RAM and presents a waitrequest-style slave interface to the memory bus arbiter.

Parameters:
ADDR_WIDTH, 14, word-address bits implemented; depth = 2**ADDR_WIDTH words
BASE, 0, value that i_address[17:ADDR_WIDTH] must equal for the bank to respond
DATA_WIDTH, 36, word width
WAIT_STATES, 0, extra cycles between RAM access and completion (0..15)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_address  in  18  word address
i_read  in  1  read request
i_write  in  1  write request
i_rmw  in  1  qualifies i_read as the read half of an RPW cycle
i_writedata  in  DATA_WIDTH  write data
i_par_inject  in  1  force bad parity on the write (effective only with PARITY_EN)
o_readdata  out  DATA_WIDTH  registered read data
o_waitrequest  out  1  high while the current request is not yet accepted
o_paused  out  1  bank holds an RPW address and is waiting for the write half
o_nxm  out  1  one-cycle pulse: access completed outside the window
o_parerr  out  1  parity error on the last completed read

Behaviour:
- Reset: i_reset_n is synchronous, active-low, clocked by i_clk.
  - Reset values: o_readdata=0, o_waitrequest=1, o_paused=0, o_nxm=0, o_parerr=0, RAM write enable=0, state=IDLE.
  - Reset mid-operation abandons the access; no RAM write is issued afterwards. RAM contents are not cleared.
- Window decode: sel = (i_address[17:ADDR_WIDTH] == BASE); RAM index = i_address[ADDR_WIDTH-1:0].
- States: IDLE, ACCESS, WAIT, DONE, PAUSE.
- IDLE:
  - On i_read|i_write, latch address, data, kind and sel; go to ACCESS.
  - o_waitrequest stays high.
  - i_read&i_write together is treated as a write.
- ACCESS:
  - Drive the latched index to the RAM.
  - Go to WAIT if WAIT_STATES>0, else DONE.
- WAIT: counts WAIT_STATES cycles, then goes to DONE.
- DONE (exactly one cycle):
  - o_waitrequest=0.
  - Read: o_readdata is loaded from the RAM and is valid the same cycle waitrequest is low. It holds until the next completed read.
  - Write: RAM write enable pulses for exactly this one cycle.
  - Unselected access: no RAM write, o_readdata=0, o_nxm=1 for this cycle.
  - Next state is PAUSE if the access was a selected read with i_rmw, else IDLE.
- Minimum latency: request at cycle 0 gives waitrequest low at cycle 2+WAIT_STATES. Back-to-back accesses take 3+WAIT_STATES cycles each.
- PAUSE:
  - o_paused=1; o_waitrequest=1.
  - i_write: i_address is ignored; the write goes to the held index through ACCESS/WAIT/DONE; o_paused clears on entry to ACCESS.
  - i_read: the pause is abandoned; the read is treated as a fresh IDLE request in the same cycle.
  - No request: stays in PAUSE indefinitely.
- Request inputs changing while waitrequest is high are ignored; the latched values are used.

Optional Feature:
PARITY_EN
- Defined:
  - RAM is DATA_WIDTH+1 wide; writes store odd parity of the data, inverted when i_par_inject=1.
  - In a read's DONE cycle, o_parerr is set if the stored word+parity has even weight. It holds until the next completed read.
  - Unselected reads clear o_parerr.
- Undefined: RAM is DATA_WIDTH wide; o_parerr is tied 0; i_par_inject is ignored.

Test Plan:
- Default params: write 0o123456701234 to 0o00100, then read 0o00100 → waitrequest low 2 cycles after each request; readdata=0o123456701234; we pulsed exactly once.
- WAIT_STATES=3: read 0o00100 → waitrequest low at cycle 5; back-to-back second read completes at cycle 11.
- BASE=1, ADDR_WIDTH=14: write 0o777 to 0o00005 (outside the window) → no RAM change, o_nxm pulse, readdata=0; read 0o40005 → returns the prior contents.
- RPW: read with i_rmw at 0o200 (contents 0o5) → readdata=0o5, o_paused=1; write 0o6 with i_address=0o300 → RAM[0o200]=0o6, RAM[0o300] unchanged, o_paused=0.
- Reset asserted in the ACCESS state of a write → no write enable; outputs at reset values; the next read returns the old data.
- PARITY_EN: write 0o1 with i_par_inject=1, then read → o_parerr=1; clean write and read of 0o1 → o_parerr=0.
